// File: rtl/mac_seq_pkg.sv
// Shared constants for the (a*b)+(c*d) sequencer: FSM state encodings
// and the radix used by the binary-to-BCD subtract loop.
package mac_seq_pkg;

  // 3-bit state register encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MUL_AB = 3'd1;
  localparam logic [2:0] S_MUL_CD = 3'd2;
  localparam logic [2:0] S_SUM    = 3'd3;
  localparam logic [2:0] S_BCD    = 3'd4;

  // Radix subtracted once per BCD cycle
  localparam int BCD_BASE = 10;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand/result bundle between the board wrapper (master) and the
// sequencer (slave).
//
// Handshake: the master raises start (pulse or level). The slave accepts it
// only on a rising edge where it is idle (busy=0), latching a..d on that same
// edge. While busy=1, start and a..d are ignored. done is a one-cycle pulse,
// and result/bcd are valid from the done cycle until the next completed
// operation overwrites them. state mirrors the FSM register for observation.
interface mac_seq_ctrl_if #(
  parameter int OPW = 3
) ();
  logic              start;
  logic [OPW-1:0]    a;
  logic [OPW-1:0]    b;
  logic [OPW-1:0]    c;
  logic [OPW-1:0]    d;
  logic              busy;
  logic              done;
  logic [2*OPW:0]    result;
  logic [7:0]        bcd;
  logic [2:0]        state;

  modport master (
    output start, a, b, c, d,
    input  busy, done, result, bcd, state
  );

  modport slave (
    input  start, a, b, c, d,
    output busy, done, result, bcd, state
  );
endinterface

// File: rtl/mul_shared.sv
// Combinational unsigned OPW x OPW array multiplier. Each partial-product
// row is added into the running sum through a ripple chain of full adders.
module mul_shared #(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0]   x,
  input  logic [OPW-1:0]   y,
  output logic [2*OPW-1:0] p
);

  function automatic logic [1:0] full_add(input logic s, input logic t, input logic cin);
    full_add = {(s & t) | (s & cin) | (t & cin), s ^ t ^ cin};
  endfunction

  // Accumulate partial-product rows; row i occupies bits i..i+OPW-1 and its
  // carry-out lands in bit i+OPW, which earlier rows have not reached yet.
  always_comb begin : array_mul
    logic [2*OPW-1:0] acc;
    logic [OPW-1:0]   pp;
    logic             cy;
    logic [1:0]       fa;
    acc = '0;
    pp  = '0;
    cy  = 1'b0;
    fa  = '0;
    for (int j = 0; j < OPW; j++) acc[j] = x[j] & y[0];
    for (int i = 1; i < OPW; i++) begin
      pp = x & {OPW{y[i]}};
      cy = 1'b0;
      for (int j = 0; j < OPW; j++) begin
        fa         = full_add(acc[i+j], pp[j], cy);
        acc[i+j]   = fa[0];
        cy         = fa[1];
      end
      acc[i+OPW] = cy;
    end
    p = acc;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Computes (a*b)+(c*d) with one time-multiplexed multiplier, then converts
// the binary sum to two BCD digits by repeated subtraction of ten.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.slave  bus
);

  localparam int RW = 2*OPW + 1;
  localparam logic [RW-1:0] TEN = RW'(BCD_BASE);

  logic [2:0]       state;
  logic [OPW-1:0]   la, lb, lc, ld;
  logic [2*OPW-1:0] p1, p2;
  logic [RW-1:0]    rem;
  logic [3:0]       tens;
  logic [RW-1:0]    result_q;
  logic [7:0]       bcd_q;
  logic             done_q;

  logic             sel_cd;
  logic [OPW-1:0]   mx, my;
  logic [2*OPW-1:0] prod;
  logic [RW-1:0]    sum;

  // Operand mux: a,b during MUL_AB, c,d during MUL_CD
  assign sel_cd = (state == S_MUL_CD);
  assign mx     = sel_cd ? lc : la;
  assign my     = sel_cd ? ld : lb;
  assign sum    = RW'(p1) + RW'(p2);

  mul_shared #(.OPW(OPW)) u_mul (
    .x (mx),
    .y (my),
    .p (prod)
  );

  // Sequencer FSM and datapath registers; reset discards any partial work
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      la       <= '0;
      lb       <= '0;
      lc       <= '0;
      ld       <= '0;
      p1       <= '0;
      p2       <= '0;
      rem      <= '0;
      tens     <= '0;
      result_q <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            la    <= bus.a;
            lb    <= bus.b;
            lc    <= bus.c;
            ld    <= bus.d;
            state <= S_MUL_AB;
          end
        end
        S_MUL_AB: begin
          p1    <= prod;
          state <= S_MUL_CD;
        end
        S_MUL_CD: begin
          p2    <= prod;
          state <= S_SUM;
        end
        S_SUM: begin
          result_q <= sum;
          rem      <= sum;
          tens     <= '0;
          state    <= S_BCD;
        end
        S_BCD: begin
          if (rem >= TEN) begin
            rem  <= rem - TEN;
            tens <= tens + 4'd1;
          end else begin
            bcd_q  <= {tens, rem[3:0]};
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.bcd    = bcd_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: reset, nominal, extremes, busy
// protection, back-to-back operation and reset during the BCD loop.
module tb_mac_seq_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mac_seq_ctrl_if #(.OPW(3)) bus ();

  mac_seq_ctrl #(.OPW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present operands and pulse start across one rising edge
  task automatic launch(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
    bus.a = a; bus.b = b; bus.c = c; bus.d = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Wait up to budget edges for done; edges=-1 if it never comes
  task automatic wait_done(input int budget, output int edges);
    edges = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy: got %0b expected 0", bus.busy);
      end
      vectors++;
      if (bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_done: got %0b expected 0", bus.done);
      end
      vectors++;
      if (bus.result !== 7'd0) begin
        miscompares++;
        $display("FAIL reset_result: got %0d expected 0", bus.result);
      end
      vectors++;
      if (bus.bcd !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_bcd: got %h expected 00", bus.bcd);
      end
    end
  endtask

  task automatic test_nominal();
    int e;
    launch(3'd2, 3'd3, 3'd1, 3'd4);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL nominal_busy: got %0b expected 1", bus.busy);
    end
    wait_done(30, e);
    vectors++;
    if (e !== 5) begin
      miscompares++;
      $display("FAIL nominal_latency: got %0d expected 5", e);
    end
    vectors++;
    if (bus.result !== 7'd10) begin
      miscompares++;
      $display("FAIL nominal_result: got %0d expected 10", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h10) begin
      miscompares++;
      $display("FAIL nominal_bcd: got %h expected 10", bus.bcd);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_busy_at_done: got %0b expected 0", bus.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_done_width: got %0b expected 0", bus.done);
    end
  endtask

  task automatic test_max();
    int e;
    launch(3'd7, 3'd7, 3'd7, 3'd7);
    wait_done(30, e);
    vectors++;
    if (e !== 13) begin
      miscompares++;
      $display("FAIL max_latency: got %0d expected 13", e);
    end
    vectors++;
    if (bus.result !== 7'd98) begin
      miscompares++;
      $display("FAIL max_result: got %0d expected 98", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h98) begin
      miscompares++;
      $display("FAIL max_bcd: got %h expected 98", bus.bcd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int e;
    launch(3'd0, 3'd0, 3'd0, 3'd0);
    wait_done(30, e);
    vectors++;
    if (e !== 4) begin
      miscompares++;
      $display("FAIL zero_latency: got %0d expected 4", e);
    end
    vectors++;
    if (bus.result !== 7'd0) begin
      miscompares++;
      $display("FAIL zero_result: got %0d expected 0", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h00) begin
      miscompares++;
      $display("FAIL zero_bcd: got %h expected 00", bus.bcd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_protect();
    int e;
    int extra;
    launch(3'd1, 3'd1, 3'd1, 3'd1);
    @(posedge clk); #1;
    vectors++;
    if (bus.state !== 3'd2) begin
      miscompares++;
      $display("FAIL busy_state_mul_cd: got %0d expected 2", bus.state);
    end
    bus.a = 3'd7; bus.b = 3'd7; bus.c = 3'd7; bus.d = 3'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(30, e);
    vectors++;
    if (e !== 2) begin
      miscompares++;
      $display("FAIL busy_latency: got %0d expected 2 more edges", e);
    end
    vectors++;
    if (bus.result !== 7'd2) begin
      miscompares++;
      $display("FAIL busy_result: got %0d expected 2", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h02) begin
      miscompares++;
      $display("FAIL busy_bcd: got %h expected 02", bus.bcd);
    end
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL busy_extra_done: got %0d pulses expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    bus.a = 3'd3; bus.b = 3'd3; bus.c = 3'd0; bus.d = 3'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 3'd5; bus.b = 3'd5; bus.c = 3'd5; bus.d = 3'd5;
    wait_done(30, e);
    vectors++;
    if (e !== 4) begin
      miscompares++;
      $display("FAIL b2b_first_latency: got %0d expected 4", e);
    end
    vectors++;
    if (bus.result !== 7'd9) begin
      miscompares++;
      $display("FAIL b2b_first_result: got %0d expected 9", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h09) begin
      miscompares++;
      $display("FAIL b2b_first_bcd: got %h expected 09", bus.bcd);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.state !== 3'd1) begin
      miscompares++;
      $display("FAIL b2b_no_dead_cycle: got state %0d expected 1", bus.state);
    end
    wait_done(30, e);
    bus.start = 1'b0;
    vectors++;
    if (e !== 9) begin
      miscompares++;
      $display("FAIL b2b_second_latency: got %0d expected 9", e);
    end
    vectors++;
    if (bus.result !== 7'd50) begin
      miscompares++;
      $display("FAIL b2b_second_result: got %0d expected 50", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h50) begin
      miscompares++;
      $display("FAIL b2b_second_bcd: got %h expected 50", bus.bcd);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_after: got %0b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    launch(3'd7, 3'd7, 3'd7, 3'd7);
    repeat (5) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (bus.state !== 3'd4) begin
      miscompares++;
      $display("FAIL midrst_in_bcd: got state %0d expected 4", bus.state);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (bus.state !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_state: got %0d expected 0", bus.state);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_busy: got %0b expected 0", bus.busy);
    end
    vectors++;
    if (bus.result !== 7'd0) begin
      miscompares++;
      $display("FAIL midrst_result: got %0d expected 0", bus.result);
    end
    vectors++;
    if (bus.bcd !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_bcd: got %h expected 00", bus.bcd);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midrst_no_done: got %0d pulses expected 0", seen);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_nominal();
    test_max();
    test_zero();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that computes (a*b)+(c*d) using a single shared multiplier instance, time-multiplexed over two cycles, instead of two parallel multipliers. It then converts the 7-bit binary sum to two BCD digits by iterative subtraction. It sits between the switch/operand inputs and the HEX display encoders, and exposes a start/busy/done handshake for a top-level board wrapper.

Parameters:
OPW, 3, operand width in bits; supported values are 2 and 3, so the result never exceeds 98 and always fits in two BCD digits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
start  in  1  request pulse or level; accepted only in IDLE.
a  in  OPW  operand a.
b  in  OPW  operand b.
c  in  OPW  operand c.
d  in  OPW  operand d.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse; result and bcd are valid from this cycle onward.
result  out  2*OPW+1  binary sum a*b + c*d.
bcd  out  8  [7:4] tens digit, [3:0] ones digit of result.

Behaviour:
- One clock. Reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE.
  - busy=0, done=0, result=0, bcd=8'h00.
  - All internal registers (operand latches, p1, p2, rem, tens) <= 0.
  - Reset has priority over every other event, including mid-operation; a partial computation is discarded with no done pulse.
- States: IDLE, MUL_AB, MUL_CD, SUM, BCD.
  - IDLE: if start=1, latch a/b/c/d and go to MUL_AB; otherwise stay.
  - MUL_AB: shared multiplier mux selects the latched a,b; p1 <= product; go to MUL_CD.
  - MUL_CD: mux selects the latched c,d; p2 <= product; go to SUM.
  - SUM: result <= p1+p2 (zero-extended, no overflow); rem <= p1+p2; tens <= 0; go to BCD.
  - BCD, rem>=10: rem <= rem-10; tens <= tens+1; stay in BCD.
  - BCD, rem<10: bcd <= {tens, rem[3:0]}; done <= 1; go to IDLE.
- done is registered and high for exactly one cycle; it is 0 in all other cycles.
- Latency: if start is sampled at edge k, done is high in the cycle following edge k+4+T, where T = result/10.
  - Minimum latency 4 edges (result 0..9).
  - Maximum latency 13 edges (result 98).
- result and bcd hold their values until overwritten by the next completed operation. They do not change during a new operation until SUM (result) or BCD exit (bcd).
- result updates at SUM, before done; the bench samples result only on done.
- start while busy=1 is ignored: no operand relatch, no queueing.
- start held high continuously: a new operation begins in the IDLE cycle in which done is high, because the state is already IDLE then. Back-to-back ops have no dead cycle between done and the next MUL_AB.
- Operands are captured only at acceptance. Changes to a..d during busy have no effect.
- Width rules:
  - Products are 2*OPW bits, unsigned.
  - Sum is 2*OPW+1 bits, unsigned.
  - The tens counter is 4 bits and never exceeds 9.
- Illegal state encodings return to IDLE on the next edge with done=0.

Decomposition:
- Shared package mac_seq_pkg holds:
  - the state encoding constants (IDLE=0, MUL_AB=1, MUL_CD=2, SUM=3, BCD=4, in a 3-bit state register);
  - BCD_BASE=10.
  - OPW stays a module parameter.
- One sub-module, mul_shared: purely combinational unsigned OPW x OPW array multiplier built from full adders, with 2*OPW-bit output. It is instantiated exactly once and fed by the controller's 2:1 operand mux.
- The BCD subtract loop stays inline in mac_seq_ctrl.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then rst_n=1 with start=0 for 5 cycles -> busy=0, done=0, result=0, bcd=8'h00 throughout.
- Nominal: a=2,b=3,c=1,d=4, start pulsed at edge k -> busy high from k; result=10; bcd=8'h10; done high after edge k+5 for one cycle only.
- Maximum: a=b=c=d=7 -> result=98, bcd=8'h98, done after edge k+13. Also a=b=c=d=0 -> result=0, bcd=8'h00, done after edge k+4.
- Busy protection: start a=1,b=1,c=1,d=1; change operands to all 7 and pulse start again during MUL_CD -> result=2, bcd=8'h02, exactly one done pulse.
- Back-to-back: start held high, first op a=3,b=3,c=0,d=0 -> first done with result=9. The same cycle accepts new operands a=5,b=5,c=5,d=5 -> second done 4+5 edges later with result=50, bcd=8'h50.
- Reset mid-op: start a=b=c=d=7, drop rst_n during BCD state (3rd BCD cycle) -> next cycle: state IDLE, busy=0, result=0, bcd=0, and no done pulse ever appears for that operation.
